// File: rtl/mem_stage_if.sv
// EXE->MEM->WB pipeline bus plus the data-SRAM port of the MEM stage.
// master is the MEM stage's view; slave is the surrounding pipeline/SRAM.
interface mem_stage_if;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic        exe_res_from_mem;
  logic [7:0]  exe_mem_all;
  logic [5:0]  exe_rf_all;
  logic [31:0] exe_rkd_value;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [5:0]  mem_rf_all;
  logic [31:0] mem_final_result;
  logic [37:0] mem_fwd_all;

  modport master (
    input  exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem, exe_mem_all,
           exe_rf_all, exe_rkd_value, data_sram_rdata, wb_allowin,
    output mem_allowin, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           mem_to_wb_valid, mem_valid, mem_pc, mem_rf_all, mem_final_result, mem_fwd_all
  );

  modport slave (
    output exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem, exe_mem_all,
           exe_rf_all, exe_rkd_value, data_sram_rdata, wb_allowin,
    input  mem_allowin, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           mem_to_wb_valid, mem_valid, mem_pc, mem_rf_all, mem_final_result, mem_fwd_all
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: SRAM request issued on EXE->MEM transfer, load data aligned one cycle later.
// Never stalls itself; holds state (and buffered read data) only while WB back-pressures.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.master bus
);
  logic        mem_valid;
  logic        mem_first;
  logic [31:0] mem_pc;
  logic [31:0] mem_result;
  logic        mem_res_from_mem;
  logic        mem_ld_b;
  logic        mem_ld_h;
  logic        mem_ld_w;
  logic        mem_ld_ue;
  logic [1:0]  mem_off;
  logic [5:0]  mem_rf_all;
  logic [31:0] rdata_buf;

  logic        xfer;
  logic        st_mem_we;
  logic        st_b;
  logic        st_h;
  logic        st_w;
  logic [1:0]  st_off;
  logic [3:0]  we_sel;
  logic [31:0] wdata_sel;
  logic [31:0] rd_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign bus.mem_allowin     = ~mem_valid | bus.wb_allowin;
  assign bus.mem_to_wb_valid = mem_valid;
  assign xfer                = bus.exe_to_mem_valid & bus.mem_allowin;

  assign st_mem_we = bus.exe_mem_all[7];
  assign st_b      = bus.exe_mem_all[2];
  assign st_h      = bus.exe_mem_all[1];
  assign st_w      = bus.exe_mem_all[0];
  assign st_off    = bus.exe_result[1:0];

  always_comb begin
    we_sel    = 4'b0000;
    wdata_sel = bus.exe_rkd_value;
    if (st_b) begin
      we_sel    = 4'b0001 << st_off;
      wdata_sel = {4{bus.exe_rkd_value[7:0]}};
    end else if (st_h) begin
      we_sel    = st_off[1] ? 4'b1100 : 4'b0011;
      wdata_sel = {2{bus.exe_rkd_value[15:0]}};
    end else if (st_w) begin
      we_sel    = 4'b1111;
    end
  end

  // Gated by xfer so a store held in EXE during a stall is written exactly once.
  assign bus.data_sram_en    = xfer & (bus.exe_res_from_mem | st_mem_we);
  assign bus.data_sram_we    = (xfer & st_mem_we) ? we_sel : 4'b0000;
  assign bus.data_sram_addr  = bus.exe_result;
  assign bus.data_sram_wdata = wdata_sel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid        <= 1'b0;
      mem_first        <= 1'b0;
      mem_pc           <= 32'd0;
      mem_result       <= 32'd0;
      mem_res_from_mem <= 1'b0;
      mem_ld_b         <= 1'b0;
      mem_ld_h         <= 1'b0;
      mem_ld_w         <= 1'b0;
      mem_ld_ue        <= 1'b0;
      mem_off          <= 2'd0;
      mem_rf_all       <= 6'd0;
      rdata_buf        <= 32'd0;
    end else begin
      if (bus.mem_allowin) mem_valid <= bus.exe_to_mem_valid;
      mem_first <= xfer;
      if (xfer) begin
        mem_pc           <= bus.exe_pc;
        mem_result       <= bus.exe_result;
        mem_res_from_mem <= bus.exe_res_from_mem;
        mem_ld_b         <= bus.exe_mem_all[6];
        mem_ld_h         <= bus.exe_mem_all[5];
        mem_ld_w         <= bus.exe_mem_all[4];
        mem_ld_ue        <= bus.exe_mem_all[3];
        mem_off          <= bus.exe_result[1:0];
        mem_rf_all       <= bus.exe_rf_all;
      end
      if (mem_first) rdata_buf <= bus.data_sram_rdata;
    end
  end

  // SRAM read data is only live in the first MEM cycle; afterwards replay the capture.
  assign rd_data = mem_first ? bus.data_sram_rdata : rdata_buf;
  assign ld_byte = rd_data[{mem_off, 3'b000} +: 8];
  assign ld_half = rd_data[{mem_off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'd0;
    if (mem_ld_b)      load_data = {{24{~mem_ld_ue & ld_byte[7]}}, ld_byte};
    else if (mem_ld_h) load_data = {{16{~mem_ld_ue & ld_half[15]}}, ld_half};
    else if (mem_ld_w) load_data = rd_data;
  end

  assign final_result         = mem_res_from_mem ? load_data : mem_result;
  assign bus.mem_valid        = mem_valid;
  assign bus.mem_pc           = mem_pc;
  assign bus.mem_rf_all       = mem_rf_all;
  assign bus.mem_final_result = final_result;
  assign bus.mem_fwd_all      = {mem_rf_all[5] & mem_valid, mem_rf_all[4:0], final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-instruction vectors plus
// hand-written stall, back-to-back and reset sequences.
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus.master));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  mem_all;
    logic        res_from_mem;
    logic [31:0] addr;
    logic [31:0] rkd;
    logic [31:0] rdata;
    logic        en;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] result;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_exe(input logic vld, input logic [31:0] pc, input logic [31:0] res,
                           input logic rfm, input logic [7:0] mall, input logic [5:0] rf,
                           input logic [31:0] rkd);
    bus.exe_to_mem_valid = vld;
    bus.exe_pc           = pc;
    bus.exe_result       = res;
    bus.exe_res_from_mem = rfm;
    bus.exe_mem_all      = mall;
    bus.exe_rf_all       = rf;
    bus.exe_rkd_value    = rkd;
  endtask

  initial begin
    //          mem_all rfm addr          rkd           rdata         en we     wdata         result
    vecs[0]  = '{8'h84, 1'b0, 32'h00001002, 32'h000000AB, 32'h0,        1'b1, 4'b0100, 32'hABABABAB, 32'h00001002};
    vecs[1]  = '{8'h40, 1'b1, 32'h00002003, 32'h0,        32'h80FF0000, 1'b1, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{8'h48, 1'b1, 32'h00002003, 32'h0,        32'h80FF0000, 1'b1, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{8'h20, 1'b1, 32'h00002002, 32'h0,        32'h80011234, 1'b1, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{8'h28, 1'b1, 32'h00002000, 32'h0,        32'h80011234, 1'b1, 4'b0000, 32'h0,        32'h00001234};
    vecs[5]  = '{8'h10, 1'b1, 32'h00003000, 32'h0,        32'hDEADBEEF, 1'b1, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{8'h82, 1'b0, 32'h00002002, 32'h12345678, 32'h0,        1'b1, 4'b1100, 32'h56785678, 32'h00002002};
    vecs[7]  = '{8'h82, 1'b0, 32'h00002001, 32'h12345678, 32'h0,        1'b1, 4'b0011, 32'h56785678, 32'h00002001};
    vecs[8]  = '{8'h81, 1'b0, 32'h00002003, 32'hCAFEF00D, 32'h0,        1'b1, 4'b1111, 32'hCAFEF00D, 32'h00002003};
    vecs[9]  = '{8'h84, 1'b0, 32'h00001000, 32'h000000CD, 32'h0,        1'b1, 4'b0001, 32'hCDCDCDCD, 32'h00001000};
    vecs[10] = '{8'h00, 1'b0, 32'h0000ABCD, 32'h00000055, 32'h0,        1'b0, 4'b0000, 32'h00000055, 32'h0000ABCD};
    vecs[11] = '{8'h40, 1'b1, 32'h00002001, 32'h0,        32'h00007F00, 1'b1, 4'b0000, 32'h0,        32'h0000007F};
    vecs[12] = '{8'h48, 1'b1, 32'h00002002, 32'h0,        32'h00AB0000, 1'b1, 4'b0000, 32'h0,        32'h000000AB};

    resetn = 1'b0;
    bus.wb_allowin = 1'b1;
    bus.data_sram_rdata = 32'h0;
    drive_exe(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 6'h00, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", 0, {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_to_wb_valid", 0, {31'd0, bus.mem_to_wb_valid}, 32'd0);
    chk("rst_fwd_we", 0, {31'd0, bus.mem_fwd_all[37]}, 32'd0);
    chk("rst_rf_all", 0, {26'd0, bus.mem_rf_all}, 32'd0);
    chk("rst_pc", 0, bus.mem_pc, 32'd0);
    chk("rst_allowin", 0, {31'd0, bus.mem_allowin}, 32'd1);
    chk("rst_sram_en", 0, {31'd0, bus.data_sram_en}, 32'd0);
    resetn = 1'b1;

    // Table: one instruction per vector, SRAM side checked in the transfer cycle,
    // result checked the cycle after with rdata presented only then.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.data_sram_rdata = 32'h0;
      drive_exe(1'b1, 32'h00000400 + 32'(i * 4), vecs[i].addr, vecs[i].res_from_mem,
                vecs[i].mem_all, 6'h21, vecs[i].rkd);
      #1;
      chk("sram_en", i, {31'd0, bus.data_sram_en}, {31'd0, vecs[i].en});
      chk("sram_we", i, {28'd0, bus.data_sram_we}, {28'd0, vecs[i].we});
      chk("sram_wdata", i, bus.data_sram_wdata, vecs[i].wdata);
      chk("sram_addr", i, bus.data_sram_addr, vecs[i].addr);
      @(negedge clk);
      bus.exe_to_mem_valid = 1'b0;
      bus.data_sram_rdata = vecs[i].rdata;
      #1;
      chk("final_result", i, bus.mem_final_result, vecs[i].result);
      chk("en_one_cycle", i, {31'd0, bus.data_sram_en}, 32'd0);
    end

    // Stall: ld_w held 3 extra cycles while a store waits in EXE.
    @(negedge clk);
    drive_exe(1'b1, 32'h00000800, 32'h00004000, 1'b1, 8'h10, 6'h27, 32'h0);
    @(negedge clk);
    drive_exe(1'b1, 32'h00000804, 32'h00005000, 1'b0, 8'h81, 6'h00, 32'h99887766);
    bus.wb_allowin = 1'b0;
    bus.data_sram_rdata = 32'h11112222;
    #1;
    chk("stall_first_result", 0, bus.mem_final_result, 32'h11112222);
    for (int c = 1; c <= 3; c++) begin
      chk("stall_allowin", c, {31'd0, bus.mem_allowin}, 32'd0);
      chk("stall_sram_en", c, {31'd0, bus.data_sram_en}, 32'd0);
      @(negedge clk);
      bus.data_sram_rdata = 32'h33334444 + 32'(c);
      #1;
      chk("stall_result", c, bus.mem_final_result, 32'h11112222);
      chk("stall_valid", c, {31'd0, bus.mem_valid}, 32'd1);
      chk("stall_pc", c, bus.mem_pc, 32'h00000800);
    end
    bus.wb_allowin = 1'b1;
    #1;
    chk("release_sram_en", 0, {31'd0, bus.data_sram_en}, 32'd1);
    chk("release_sram_we", 0, {28'd0, bus.data_sram_we}, 32'hF);
    chk("release_result", 0, bus.mem_final_result, 32'h11112222);
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b0;
    #1;
    chk("replace_pc", 0, bus.mem_pc, 32'h00000804);
    chk("replace_result", 0, bus.mem_final_result, 32'h00005000);
    chk("replace_valid", 0, {31'd0, bus.mem_valid}, 32'd1);

    // Back-to-back ALU ops: result and forwarding are EXE values delayed by one cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_exe(1'b1, 32'h00000100 + 32'(i * 4), 32'h00001000 + 32'(i), 1'b0, 8'h00,
                {1'b1, 5'(i + 1)}, 32'h0);
      if (i > 0) begin
        #1;
        chk("b2b_result", i, bus.mem_final_result, 32'h00001000 + 32'(i - 1));
        chk("b2b_pc", i, bus.mem_pc, 32'h00000100 + 32'((i - 1) * 4));
        chk("b2b_fwd_rf", i, {26'd0, bus.mem_fwd_all[37:32]}, {26'd0, 1'b1, 5'(i)});
        chk("b2b_fwd_data", i, bus.mem_fwd_all[31:0], 32'h00001000 + 32'(i - 1));
      end
    end
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b0;
    #1;
    chk("b2b_last_result", 0, bus.mem_final_result, 32'h00001004);
    @(negedge clk);
    chk("b2b_drain_valid", 0, {31'd0, bus.mem_valid}, 32'd0);
    chk("b2b_drain_fwd_we", 0, {31'd0, bus.mem_fwd_all[37]}, 32'd0);

    // Reset while a load is held under WB back-pressure.
    drive_exe(1'b1, 32'h00000900, 32'h00006000, 1'b1, 8'h10, 6'h2A, 32'h0);
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b0;
    bus.wb_allowin = 1'b0;
    #1;
    chk("pre_rst_fwd_we", 0, {31'd0, bus.mem_fwd_all[37]}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 0, {31'd0, bus.mem_valid}, 32'd0);
    chk("midrst_fwd_we", 0, {31'd0, bus.mem_fwd_all[37]}, 32'd0);
    chk("midrst_rf_all", 0, {26'd0, bus.mem_rf_all}, 32'd0);
    chk("midrst_allowin", 0, {31'd0, bus.mem_allowin}, 32'd1);
    resetn = 1'b1;
    bus.wb_allowin = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EXE stage and the WB stage. Issues the data-SRAM request in the cycle an instruction transfers from EXE into MEM, holds that instruction for one or more cycles, and aligns/extends load data. Produces the write-back result for WB and a forwarding bundle for ID hazard/bypass logic. The stage never stalls on its own; it stalls only on WB back-pressure.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- exe_to_mem_valid  in  1  EXE holds a completed instruction
- mem_allowin  out  1  MEM accepts an instruction this cycle
- exe_pc  in  32  PC of the incoming instruction
- exe_result  in  32  ALU/mul/div result; memory address for loads/stores
- exe_res_from_mem  in  1  incoming instruction is a load
- exe_mem_all  in  8  {mem_we, ld_b, ld_h, ld_w, ld_ue, st_b, st_h, st_w}
- exe_rf_all  in  6  {rf_we, rf_waddr[4:0]}
- exe_rkd_value  in  32  store data
- data_sram_en  out  1  SRAM access enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  write data, lane-replicated
- data_sram_rdata  in  32  read data, valid one cycle after request
- wb_allowin  in  1  WB accepts
- mem_to_wb_valid  out  1  instruction ready for WB
- mem_valid  out  1  MEM holds a valid instruction
- mem_pc  out  32  PC in MEM
- mem_rf_all  out  6  {rf_we, rf_waddr}
- mem_final_result  out  32  load data or passed-through exe_result
- mem_fwd_all  out  38  {mem_rf_we & mem_valid, mem_rf_waddr, mem_final_result}

## Operation
- Handshake: mem_ready_go = 1; mem_allowin = ~mem_valid | wb_allowin; mem_to_wb_valid = mem_valid.
- Transfer-in: xfer = exe_to_mem_valid & mem_allowin. On xfer, latch pc, result, res_from_mem, load type, addr[1:0], rf_all. mem_valid <= xfer each cycle a transfer is possible (mem_valid <= exe_to_mem_valid when mem_allowin, else hold).
- SRAM request is combinational from EXE inputs: data_sram_en = xfer & (res_from_mem | mem_we); addr = exe_result; nothing is issued without xfer. This prevents duplicate stores under stall.
- Store byte enables (off = exe_result[1:0]), gated by xfer & mem_we:
  - st_b: 4'b0001 << off; wdata = {4{rkd[7:0]}}
  - st_h: off[1] ? 4'b1100 : 4'b0011; wdata = {2{rkd[15:0]}}
  - st_w: 4'b1111; wdata = rkd
- Alignment is not checked; misaligned addresses use the same low-bit rules.
- Read-data hold: the mem_first flag is set on xfer and cleared the next cycle. While mem_first = 1, use live rdata and capture it into rdata_buf. Otherwise use rdata_buf. Stalled loads therefore see stable data.
- Load extract (latched off):
  - ld_b: byte = data[8*off +: 8], sign-extended unless ld_ue
  - ld_h: half = data[16*off[1] +: 16], sign/zero per ld_ue
  - ld_w: data
- mem_final_result = res_from_mem ? load_data : latched result.

## Timing
- Reset (resetn = 0 at clk edge): mem_valid = 0, mem_first = 0, mem_rf_all = 0, mem_pc = 0, rdata_buf = 0. Outputs follow: mem_to_wb_valid = 0, mem_fwd_all[37] = 0, data_sram_en and we are 0 whenever exe_to_mem_valid = 0.
- Load latency: request in cycle T (xfer); rdata is valid in T+1, when the instruction is in MEM. mem_final_result is valid combinationally in T+1.
- Stall: mem_valid & ~wb_allowin holds all latched state, and mem_allowin = 0. mem_final_result stays constant via rdata_buf.
- Simultaneous leave/enter: when wb_allowin = 1 and exe_to_mem_valid = 1, the new instruction replaces the old one in the same edge, with no bubble.
- An empty MEM always accepts.
- Reset mid-operation discards the held instruction. Any SRAM request in the reset cycle is suppressed only if EXE deasserts valid; EXE is reset in the same cycle.

## Test plan
- st_b, addr 0x1002, rkd 0x000000AB -> en = 1, we = 4'b0100, wdata = 0xABABABAB, asserted for exactly one cycle.
- ld_b at off 3, rdata 0x80FF_0000: ld_ue = 0 -> 0xFFFFFF80; ld_ue = 1 -> 0x00000080.
- ld_h at off 2, rdata 0x8001_1234 -> signed 0xFFFF8001.
- ld_w then 3-cycle wb_allowin = 0, with SRAM rdata changed after cycle 1 -> mem_final_result stays at the first-cycle value. mem_allowin = 0 and no SRAM enable during the stall.
- Back-to-back ALU ops with wb_allowin = 1 -> one instruction per cycle, mem_final_result = exe_result delayed by 1. mem_fwd_all[37:32] matches rf_all while valid.
- Reset asserted while a load is held -> next cycle mem_valid = 0, mem_fwd_all[37] = 0, mem_rf_all = 0.
